key_debounce_multi: RTL and testbench
=====================================

// Module: key_debounce_multi
// PURPOSE
//   Parametrised N-channel push-button conditioner. Each key: 2-FF synchroniser,
//   independent debounce counter, debounced level, one-cycle press/release
//   strobes, long-press strobe and optional auto-repeat strobe. Sits between
//   board key pins and control FSMs (menu/mode select); replaces single-shot
//   debounce for all key inputs.
// PARAMETERS
//   N_KEYS       3          number of independent key channels
//   DEBOUNCE_CYC 1_000_000  cycles raw input must differ stably before accepted (>=2)
//   LONG_CYC     50_000_000 cycles of continuous debounced press before long_press (>=2)
//   REPEAT_CYC   10_000_000 period of repeat strobes after long_press (>=2)
//   REPEAT_EN    1          1: emit repeat strobes while held; 0: never
//   ACTIVE_LOW   1          1: pin low = pressed; 0: pin high = pressed
// PORTS
//   clk         in   1       system clock, all logic on rising edge
//   rst         in   1       synchronous, active-high reset
//   key         in   N_KEYS  raw asynchronous key pins
//   key_level   out  N_KEYS  debounced state, 1 = pressed (polarity normalised)
//   key_press   out  N_KEYS  1-cycle strobe on accepted press
//   key_release out  N_KEYS  1-cycle strobe on accepted release
//   long_press  out  N_KEYS  1-cycle strobe when hold reaches LONG_CYC
//   key_repeat  out  N_KEYS  1-cycle strobe every REPEAT_CYC after long_press
// BEHAVIOUR
//   - Interface: one clock; reset is synchronous and active-high.
//   - Reset: all outputs 0; all counters 0; sync FFs loaded with released
//     pin level (ACTIVE_LOW ? 1 : 0) so no strobe is produced leaving reset.
//     rst mid-press aborts that press silently: no release strobe emitted.
//   - Sync: s[i] = 2nd sync FF XOR ACTIVE_LOW (1 = pressed). Async pin never
//     used elsewhere.
//   - Debounce, per channel: if s != key_level: cnt++; when cnt==DEBOUNCE_CYC-1
//     and s still != key_level: key_level<=s, cnt<=0, and on the same edge
//     key_press (s=1) or key_release (s=0) <= 1 for one cycle.
//     If s == key_level at any cycle: cnt<=0 (any glitch restarts the count).
//   - Latency: pin change -> key_level/strobe = 2 (sync) + DEBOUNCE_CYC cycles.
//   - Hold timer: hold_cnt runs only while key_level=1; cleared on release.
//     long_press pulses once when hold_cnt reaches LONG_CYC-1 (counted from the
//     cycle key_press is high). Afterwards, if REPEAT_EN, rep_cnt counts 0..
//     REPEAT_CYC-1 and key_repeat pulses at each wrap; first repeat
//     REPEAT_CYC cycles after long_press. hold_cnt saturates (no wrap).
//   - Release before LONG_CYC: no long_press, no repeat. Release on the same
//     cycle a repeat would fire: release wins, repeat suppressed.
//   - Channels fully independent; simultaneous events on several keys each
//     produce their own strobes in the same cycle.
//   - Counter widths $clog2(param); no overflow for any legal parameter value.
//   - Strobes mutually exclusive per channel per cycle; all outputs registered.
// TESTING  (bench: N_KEYS=3, DEBOUNCE_CYC=10, LONG_CYC=50, REPEAT_CYC=20, ACTIVE_LOW=1)
//   1 key[0] 1->0 held 100 cyc -> key_press[0] once at cycle 12, key_level[0]=1
//     from 12; long_press[0] at cycle 61; key_repeat[0] at 81; others stay 0.
//   2 key[1] bounces (low 4 cyc, high 2, low 6, high 1) then low steady ->
//     no strobe during bounce; single key_press[1] 12 cyc after final low edge.
//   3 key[0] held 30 cyc then released -> one press, one release 12 cyc after
//     rising pin edge, no long_press/key_repeat.
//   4 keys 0 and 2 pressed same cycle -> key_press=3'b101 in one cycle.
//   5 rst=1 for 1 cyc while key[2] held pressed 40 cyc -> all outputs 0 next
//     cycle, no key_release[2]; press re-detected 12 cyc after rst falls.
//   6 REPEAT_EN=0, key held 200 cyc -> exactly one long_press, zero repeats.

Source files
------------

// File: rtl/key_debounce_multi.sv
// N-channel push-button conditioner: two-flop synchroniser, per-key debounce,
// press/release strobes, long-press detection and optional auto-repeat.
module key_debounce_multi #(
  parameter int N_KEYS       = 3,
  parameter int DEBOUNCE_CYC = 1_000_000,
  parameter int LONG_CYC     = 50_000_000,
  parameter int REPEAT_CYC   = 10_000_000,
  parameter bit REPEAT_EN    = 1'b1,
  parameter bit ACTIVE_LOW   = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_KEYS-1:0] key,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic [N_KEYS-1:0] long_press,
  output logic [N_KEYS-1:0] key_repeat
);

  localparam int DW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam int HW = (LONG_CYC > 1) ? $clog2(LONG_CYC) : 1;
  localparam int RW = (REPEAT_CYC > 1) ? $clog2(REPEAT_CYC) : 1;

  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYC - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYC - 1);
  localparam logic [HW-1:0] HOLD_PRE  = HW'(LONG_CYC - 2);
  localparam logic [RW-1:0] REP_LAST  = RW'(REPEAT_CYC - 1);
  localparam logic [N_KEYS-1:0] IDLE_PINS = {N_KEYS{ACTIVE_LOW}};

  logic [N_KEYS-1:0] sync1_r;
  logic [N_KEYS-1:0] sync2_r;
  logic [N_KEYS-1:0] pressed_s;

  // Two-flop synchroniser, preset to the released pin level so reset exit is silent
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_r <= IDLE_PINS;
      sync2_r <= IDLE_PINS;
    end else begin
      sync1_r <= key;
      sync2_r <= sync1_r;
    end
  end

  assign pressed_s = sync2_r ^ IDLE_PINS;

  for (genvar g = 0; g < N_KEYS; g++) begin : gen_ch
    logic [DW-1:0] db_cnt_r;
    logic [HW-1:0] hold_cnt_r;
    logic [RW-1:0] rep_cnt_r;
    logic          level_r;
    logic          press_r;
    logic          release_r;
    logic          long_r;
    logic          repeat_r;
    logic          change_s;
    logic          accept_s;

    assign change_s = (pressed_s[g] != level_r);
    assign accept_s = change_s && (db_cnt_r == DB_LAST);

    // Debounce, hold timer and strobe generation for one key
    always_ff @(posedge clk) begin
      if (rst) begin
        db_cnt_r   <= {DW{1'b0}};
        hold_cnt_r <= {HW{1'b0}};
        rep_cnt_r  <= {RW{1'b0}};
        level_r    <= 1'b0;
        press_r    <= 1'b0;
        release_r  <= 1'b0;
        long_r     <= 1'b0;
        repeat_r   <= 1'b0;
      end else begin
        press_r   <= 1'b0;
        release_r <= 1'b0;
        long_r    <= 1'b0;
        repeat_r  <= 1'b0;

        if (!change_s) begin
          db_cnt_r <= {DW{1'b0}};
        end else if (accept_s) begin
          db_cnt_r  <= {DW{1'b0}};
          level_r   <= pressed_s[g];
          press_r   <= pressed_s[g];
          release_r <= ~pressed_s[g];
        end else begin
          db_cnt_r <= db_cnt_r + DW'(1'b1);
        end

        // A level change (press or release) restarts the hold timer and
        // pre-empts any long/repeat strobe due on the same edge.
        if (accept_s || !level_r) begin
          hold_cnt_r <= {HW{1'b0}};
          rep_cnt_r  <= {RW{1'b0}};
        end else if (hold_cnt_r != HOLD_LAST) begin
          hold_cnt_r <= hold_cnt_r + HW'(1'b1);
          long_r     <= (hold_cnt_r == HOLD_PRE);
          rep_cnt_r  <= {RW{1'b0}};
        end else if (REPEAT_EN) begin
          if (rep_cnt_r == REP_LAST) begin
            rep_cnt_r <= {RW{1'b0}};
            repeat_r  <= 1'b1;
          end else begin
            rep_cnt_r <= rep_cnt_r + RW'(1'b1);
          end
        end else begin
          rep_cnt_r <= {RW{1'b0}};
        end
      end
    end

    assign key_level[g]   = level_r;
    assign key_press[g]   = press_r;
    assign key_release[g] = release_r;
    assign long_press[g]  = long_r;
    assign key_repeat[g]  = repeat_r;
  end

endmodule

// File: tb/tb_key_debounce_multi.sv
// Scoreboard bench for key_debounce_multi: directed pin sequences push expected
// strobes (cycle, kind, mask); a negedge monitor pops and compares each strobe.
module tb_key_debounce_multi;
  localparam int NK = 3;

  logic clk = 1'b0;
  logic rst;
  logic [NK-1:0] key_a, key_b;
  logic [NK-1:0] lvl_a, prs_a, rel_a, lng_a, rep_a;
  logic [NK-1:0] lvl_b, prs_b, rel_b, lng_b, rep_b;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int          at;
    int          kind;
    logic [NK-1:0] mask;
  } evt_t;

  evt_t qa[$];
  evt_t qb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  key_debounce_multi #(.N_KEYS(NK), .DEBOUNCE_CYC(10), .LONG_CYC(50), .REPEAT_CYC(20),
                       .REPEAT_EN(1'b1), .ACTIVE_LOW(1'b1)) dut_a (
    .clk(clk), .rst(rst), .key(key_a), .key_level(lvl_a), .key_press(prs_a),
    .key_release(rel_a), .long_press(lng_a), .key_repeat(rep_a));

  key_debounce_multi #(.N_KEYS(NK), .DEBOUNCE_CYC(10), .LONG_CYC(50), .REPEAT_CYC(20),
                       .REPEAT_EN(1'b0), .ACTIVE_LOW(1'b1)) dut_b (
    .clk(clk), .rst(rst), .key(key_b), .key_level(lvl_b), .key_press(prs_b),
    .key_release(rel_b), .long_press(lng_b), .key_repeat(rep_b));

  function automatic string kind_name(input int k);
    case (k)
      0: return "press";
      1: return "release";
      2: return "long";
      3: return "repeat";
      default: return "unknown";
    endcase
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_evt(input int which, input int at, input int kind, input logic [NK-1:0] mask);
    evt_t e;
    e.at = at;
    e.kind = kind;
    e.mask = mask;
    if (which == 0) qa.push_back(e);
    else qb.push_back(e);
  endtask

  task automatic observe(input int which, input int kind, input logic [NK-1:0] mask,
                         input logic [NK-1:0] lvl);
    evt_t e;
    bit ok;
    bit empty;
    checks++;
    empty = (which == 0) ? (qa.size() == 0) : (qb.size() == 0);
    if (empty) begin
      errors++;
      $display("FAIL unexpected_%s dut%0d cycle %0d got mask %b required none",
               kind_name(kind), which, cyc, mask);
    end else begin
      if (which == 0) e = qa.pop_front();
      else e = qb.pop_front();
      ok = (e.at == cyc) && (e.kind == kind) && (e.mask == mask);
      if (kind == 0) ok = ok && ((lvl & mask) == mask);
      if (kind == 1) ok = ok && ((lvl & mask) == '0);
      if (!ok) begin
        errors++;
        $display("FAIL strobe_%s dut%0d got cycle %0d mask %b level %b, required %s cycle %0d mask %b",
                 kind_name(kind), which, cyc, mask, lvl, kind_name(e.kind), e.at, e.mask);
      end
    end
  endtask

  task automatic drain(input int which, input string name);
    int left;
    left = (which == 0) ? qa.size() : qb.size();
    checks++;
    if (left != 0) begin
      errors++;
      $display("FAIL missing_%s dut%0d got %0d strobes outstanding, required 0", name, which, left);
      if (which == 0) qa.delete();
      else qb.delete();
    end
  endtask

  // Monitor: every strobe the DUTs present is matched against the scoreboard
  always @(negedge clk) begin
    if (prs_a != '0) observe(0, 0, prs_a, lvl_a);
    if (rel_a != '0) observe(0, 1, rel_a, lvl_a);
    if (lng_a != '0) observe(0, 2, lng_a, lvl_a);
    if (rep_a != '0) observe(0, 3, rep_a, lvl_a);
    if (prs_b != '0) observe(1, 0, prs_b, lvl_b);
    if (rel_b != '0) observe(1, 1, rel_b, lvl_b);
    if (lng_b != '0) observe(1, 2, lng_b, lvl_b);
    if (rep_b != '0) observe(1, 3, rep_b, lvl_b);
  end

  initial begin
    int p;
    rst = 1'b1;
    key_a = 3'b111;
    key_b = 3'b111;
    tick(3);
    checks++;
    if ({lvl_a, prs_a, rel_a, lng_a, rep_a} != '0) begin
      errors++;
      $display("FAIL reset_state got %b required 0", {lvl_a, prs_a, rel_a, lng_a, rep_a});
    end
    rst = 1'b0;
    tick(5);

    // Long hold: press, long, two repeats, release colliding with third repeat
    p = cyc;
    key_a[0] = 1'b0;
    expect_evt(0, p + 12, 0, 3'b001);
    expect_evt(0, p + 61, 2, 3'b001);
    expect_evt(0, p + 81, 3, 3'b001);
    expect_evt(0, p + 101, 3, 3'b001);
    expect_evt(0, p + 121, 1, 3'b001);
    tick(109);
    key_a[0] = 1'b1;
    tick(40);
    drain(0, "long_hold");

    // Bouncing key[1]: only the final steady low is accepted
    p = cyc;
    expect_evt(0, p + 25, 0, 3'b010);
    expect_evt(0, p + 55, 1, 3'b010);
    key_a[1] = 1'b0; tick(4);
    key_a[1] = 1'b1; tick(2);
    key_a[1] = 1'b0; tick(6);
    key_a[1] = 1'b1; tick(1);
    key_a[1] = 1'b0; tick(30);
    key_a[1] = 1'b1; tick(30);
    drain(0, "bounce");

    // Short hold: press and release, no long press
    p = cyc;
    expect_evt(0, p + 12, 0, 3'b001);
    expect_evt(0, p + 42, 1, 3'b001);
    key_a[0] = 1'b0; tick(30);
    key_a[0] = 1'b1; tick(30);
    drain(0, "short_hold");

    // Simultaneous keys 0 and 2
    p = cyc;
    expect_evt(0, p + 12, 0, 3'b101);
    expect_evt(0, p + 32, 1, 3'b101);
    key_a = 3'b010; tick(20);
    key_a = 3'b111; tick(30);
    drain(0, "simultaneous");

    // Reset mid-press on key[2]: silent abort, re-detection afterwards
    p = cyc;
    expect_evt(0, p + 12, 0, 3'b100);
    expect_evt(0, p + 33, 0, 3'b100);
    expect_evt(0, p + 52, 1, 3'b100);
    key_a[2] = 1'b0;
    tick(20);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    checks++;
    if ({lvl_a, prs_a, rel_a, lng_a, rep_a} != '0) begin
      errors++;
      $display("FAIL mid_press_reset got %b required 0", {lvl_a, prs_a, rel_a, lng_a, rep_a});
    end
    tick(19);
    key_a[2] = 1'b1;
    tick(30);
    drain(0, "reset_abort");

    // Repeat disabled: single long press, no repeats over a 200-cycle hold
    p = cyc;
    expect_evt(1, p + 12, 0, 3'b001);
    expect_evt(1, p + 61, 2, 3'b001);
    expect_evt(1, p + 212, 1, 3'b001);
    key_b[0] = 1'b0; tick(200);
    key_b[0] = 1'b1; tick(30);
    drain(1, "no_repeat");
    drain(0, "idle_a");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
